finv_arbiter: RTL and testbench
===============================

FINV_ARBITER -- requirements
Module: finv_arbiter

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning cycles from issue on finv_m to matching result on finv_res; legal range 1..8.
REQ-002 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-003 SHALL have port rstn, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have ports req0_valid / req1_valid, input, 1 each, requester has an operand.
REQ-005 SHALL have ports req0_x / req1_x, input, 32 each, IEEE-754 single operand.
REQ-006 SHALL have ports req0_ready / req1_ready, output, 1 each, operand accepted this cycle.
REQ-007 SHALL have ports res0_valid / res1_valid, output, 1 each, result for that requester this cycle.
REQ-008 SHALL have ports res0_y / res1_y, output, 32 each, reciprocal result.
REQ-009 SHALL have port finv_m, output, 23, mantissa driven to the shared reciprocal pipe.
REQ-010 SHALL have port finv_res, input, 32, pipe result, normalised float in (0.5, 1.0].
REQ-011 SHALL have port busy, output, 1, any issue in flight.

Function
REQ-012 SHALL grant at most one requester per cycle; req<n>_ready is combinational on req valids and the priority pointer; a transfer is valid and ready high in the same cycle.
REQ-013 SHALL grant the sole valid requester when only one is valid, regardless of the pointer.
REQ-014 SHALL grant the pointed requester when both are valid, then toggle the pointer; the pointer is unchanged on single-requester or idle cycles.
REQ-015 SHALL accept back-to-back issues every cycle; the shared pipe never stalls and results are never back-pressured.
REQ-016 SHALL drive finv_m = granted x[22:0] in the grant cycle, and 0 when idle.
REQ-017 SHALL carry a LATENCY-deep side pipeline per issue: valid, requester id, sign, exponent e[7:0], class (zero/denormal, inf/NaN, normal).
REQ-018 SHALL, LATENCY cycles after issue, pulse exactly one res<id>_valid for one cycle; the other res valid stays 0.
REQ-019 SHALL compute for normal e in 1..254 with r = finv_res: out_exp = r[30:23] - e + 127, signed 10-bit arithmetic.
REQ-020 SHALL, when out_exp >= 1, give y = {sign, out_exp[7:0], r[22:0]}.
REQ-021 SHALL, when out_exp <= 0, give y = {sign, 31'b0}; this is flush-to-zero and no denormals are produced.
REQ-022 SHALL, for e == 0 (zero or denormal input), give y = {sign, 8'hFF, 23'b0}, i.e. signed infinity.
REQ-023 SHALL, for e == 255 (inf or NaN input), give y = {sign, 31'b0}; NaN is not propagated.
REQ-024 SHALL hold res<n>_y at the last driven value while res<n>_valid is 0, so consumers sample only on valid.
REQ-025 SHALL drive busy = OR of all side-pipeline valid bits.

Reset
REQ-026 SHALL, while rstn is low, asynchronously force: pointer = 0, all side-pipeline valids = 0, res0_valid = res1_valid = 0, res0_y = res1_y = 0, busy = 0, req ready = 0.
REQ-027 SHALL discard in-flight issues on reset mid-operation; no res valid for them after rstn rises, even if finv_res still carries data.
REQ-028 SHALL accept a new issue in the first clock edge with rstn high.

Verification
REQ-029 SHALL cover: req0 x=0x40000000 at cycle t, finv_res=0x3F800000 at t+LATENCY -> res0_valid=1, res0_y=0x3F000000 at t+LATENCY, res1_valid=0.
REQ-030 SHALL cover: req1 x=0x00000000 -> res1_y=0x7F800000; x=0x80000000 -> 0xFF800000; x=0x7F800000 -> 0x00000000.
REQ-031 SHALL cover: req x=0x7F000000 (2^127), finv_res=0x3F800000 -> y=0x00000000 (underflow flush).
REQ-032 SHALL cover: both valid for 4 cycles from reset -> grants 0,1,0,1, results returned in the same order with correct ids, busy high throughout.
REQ-033 SHALL cover: rstn low for 1 cycle at t+2 after an issue at t -> no res valid at t+LATENCY, busy=0 immediately.
REQ-034 SHALL cover: single requester valid every cycle for 10 cycles -> 10 grants, 10 result pulses at a fixed LATENCY offset, pointer unchanged.

Source files
------------

// File: rtl/finv_arbiter.sv
// finv_arbiter: two-requester front end for a shared floating-point reciprocal
// pipe. Grants one operand per cycle, ships its mantissa to the pipe, and carries
// sign/exponent/class alongside so the returning normalised mantissa can be
// turned back into a full single-precision reciprocal for the right requester.
module finv_arbiter #(
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req0_valid,
    input  logic [31:0] req0_x,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_x,
    output logic        req1_ready,
    output logic        res0_valid,
    output logic [31:0] res0_y,
    output logic        res1_valid,
    output logic [31:0] res1_y,
    output logic [22:0] finv_m,
    input  logic [31:0] finv_res,
    output logic        busy
);

    typedef enum logic [1:0] {
        CLS_ZERO    = 2'd0,   // zero or denormal operand
        CLS_SPECIAL = 2'd1,   // infinity or NaN operand
        CLS_NORMAL  = 2'd2
    } cls_t;

    typedef struct packed {
        logic       id;
        logic       sign;
        logic [7:0] exp;
        cls_t       cls;
    } side_t;

    logic               r_ptr;
    logic [LATENCY-1:0] r_vld;
    side_t              r_side [LATENCY];
    logic [31:0]        r_y0;
    logic [31:0]        r_y1;

    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_issue;
    logic [31:0]        w_x;
    side_t              w_side_in;
    side_t              w_last;
    logic               w_out_vld;
    logic signed [9:0]  w_out_exp;
    logic [31:0]        w_y;

    // Grant: sole valid requester wins; on contention the pointer decides.
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/case leaves it unassigned and infers a latch.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (rstn) begin
            if (req0_valid && req1_valid) begin
                w_gnt0 = ~r_ptr;
                w_gnt1 = r_ptr;
            end else begin
                w_gnt0 = req0_valid;
                w_gnt1 = req1_valid;
            end
        end
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign w_issue    = w_gnt0 | w_gnt1;
    assign w_x        = w_gnt1 ? req1_x : req0_x;
    assign finv_m     = w_issue ? w_x[22:0] : 23'd0;

    // Classify the granted operand for the side pipeline.
    always_comb begin
        w_side_in      = '0;
        w_side_in.id   = w_gnt1;
        w_side_in.sign = w_x[31];
        w_side_in.exp  = w_x[30:23];
        if (w_x[30:23] == 8'h00)      w_side_in.cls = CLS_ZERO;
        else if (w_x[30:23] == 8'hFF) w_side_in.cls = CLS_SPECIAL;
        else                          w_side_in.cls = CLS_NORMAL;
    end

    // Priority pointer flips only after a contended grant.
    // NOTE: clocked state uses non-blocking assignments so every register sees
    // the pre-edge value of every other register, independent of block order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                          r_ptr <= 1'b0;
        else if (req0_valid && req1_valid)  r_ptr <= ~r_ptr;
    end

    // Valid bits of the side pipeline; reset drops everything in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= w_issue;
            for (int i = 1; i < LATENCY; i++) r_vld[i] <= r_vld[i-1];
        end
    end

    // Side-pipeline payload, qualified everywhere by its valid bit.
    // NOTE: payload storage has no reset; it is only ever read under r_vld,
    // which is reset, so clearing the data would buy nothing.
    always_ff @(posedge clk) begin
        r_side[0] <= w_side_in;
        for (int i = 1; i < LATENCY; i++) r_side[i] <= r_side[i-1];
    end

    assign w_last    = r_side[LATENCY-1];
    assign w_out_vld = r_vld[LATENCY-1];
    assign w_out_exp = $signed({2'b00, finv_res[30:23]})
                     - $signed({2'b00, w_last.exp}) + 10'sd127;

    // Rebuild the reciprocal from the pipe mantissa and the carried operand.
    // The pipe result is positive for every legal operand, so folding its sign
    // in changes nothing for legal data.
    always_comb begin
        w_y = {w_last.sign ^ finv_res[31], 31'd0};
        case (w_last.cls)
            CLS_ZERO:    w_y = {w_last.sign, 8'hFF, 23'd0};
            CLS_SPECIAL: w_y = {w_last.sign, 31'd0};
            default: begin
                if (w_out_exp >= 10'sd1)
                    w_y = {w_last.sign ^ finv_res[31], w_out_exp[7:0], finv_res[22:0]};
            end
        endcase
    end

    assign res0_valid = w_out_vld & ~w_last.id;
    assign res1_valid = w_out_vld &  w_last.id;

    // Hold registers keep the last delivered result between pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_y0 <= 32'd0;
            r_y1 <= 32'd0;
        end else begin
            if (res0_valid) r_y0 <= w_y;
            if (res1_valid) r_y1 <= w_y;
        end
    end

    assign res0_y = res0_valid ? w_y : r_y0;
    assign res1_y = res1_valid ? w_y : r_y1;
    assign busy   = |r_vld;

endmodule

// File: tb/tb_finv_arbiter.sv
// Self-checking bench for finv_arbiter: a reference reciprocal pipe stand-in,
// an arbitration model and a scoreboard of expected results with due cycles.
module tb_finv_arbiter;

    localparam int LATENCY = 4;

    logic        clk;
    logic        rstn;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_x, req1_x;
    logic        req0_ready, req1_ready;
    logic        res0_valid, res1_valid;
    logic [31:0] res0_y, res1_y;
    logic [22:0] finv_m;
    logic [31:0] finv_res;
    logic        busy;

    typedef struct {
        int unsigned issue_cyc;
        int unsigned due;
        logic        id;
        logic [31:0] y;
    } exp_t;

    exp_t        sb[$];
    int          total;
    int          bad;
    int unsigned cyc;
    logic        model_ptr;
    logic [31:0] last_y0, last_y1;
    logic [22:0] tb_pipe [LATENCY];

    finv_arbiter #(.LATENCY(LATENCY)) dut (
        .clk(clk), .rstn(rstn),
        .req0_valid(req0_valid), .req0_x(req0_x), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_x(req1_x), .req1_ready(req1_ready),
        .res0_valid(res0_valid), .res0_y(res0_y),
        .res1_valid(res1_valid), .res1_y(res1_y),
        .finv_m(finv_m), .finv_res(finv_res), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in reciprocal pipe: exact for mantissa 0, otherwise any value in [0.5,1).
    function automatic logic [31:0] recip_model(input logic [22:0] m);
        if (m == 23'd0) return 32'h3F80_0000;
        return {1'b0, 8'd126, ~m};
    endfunction

    function automatic logic [31:0] exp_y(input logic [31:0] x);
        logic [31:0] r;
        int          oe;
        r = recip_model(x[22:0]);
        if (x[30:23] == 8'h00) return {x[31], 8'hFF, 23'd0};
        if (x[30:23] == 8'hFF) return {x[31], 31'd0};
        oe = int'(r[30:23]) - int'(x[30:23]) + 127;
        if (oe >= 1) return {x[31], oe[7:0], r[22:0]};
        return {x[31], 31'd0};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Fixed-latency pipe model driven from finv_m.
    always @(posedge clk) begin
        tb_pipe[0] <= finv_m;
        for (int i = 1; i < LATENCY; i++) tb_pipe[i] <= tb_pipe[i-1];
    end
    assign finv_res = recip_model(tb_pipe[LATENCY-1]);

    // Result monitor: busy, pulse exclusivity, scoreboard pops and hold values.
    always @(negedge clk) begin
        logic busy_exp;
        exp_t e;
        while (sb.size() > 0 && sb[0].due < cyc) begin
            total++; bad++;
            $display("FAIL missing_result: id=%0d due=%0d, no pulse seen by cycle %0d", sb[0].id, sb[0].due, cyc);
            void'(sb.pop_front());
        end
        busy_exp = 1'b0;
        foreach (sb[i]) if (sb[i].issue_cyc < cyc) busy_exp = 1'b1;
        total++;
        if (busy !== busy_exp) begin
            bad++; $display("FAIL busy: cycle %0d got %b expected %b", cyc, busy, busy_exp);
        end
        total++;
        if (res0_valid === 1'b1 && res1_valid === 1'b1) begin
            bad++; $display("FAIL both_res_valid: cycle %0d got 1/1 expected at most one", cyc);
        end
        total++;
        if (res0_valid === 1'b1) begin
            if (sb.size() == 0) begin
                bad++; $display("FAIL spurious_res0: cycle %0d y=%h expected no pulse", cyc, res0_y);
            end else begin
                e = sb.pop_front();
                if (e.id !== 1'b0 || e.due != cyc || res0_y !== e.y) begin
                    bad++; $display("FAIL res0: cycle %0d got id0 y=%h, expected id%0d y=%h due %0d", cyc, res0_y, e.id, e.y, e.due);
                end
                last_y0 = e.y;
            end
        end else if (res0_y !== last_y0) begin
            bad++; $display("FAIL hold_y0: cycle %0d got %h expected %h", cyc, res0_y, last_y0);
        end
        total++;
        if (res1_valid === 1'b1) begin
            if (sb.size() == 0) begin
                bad++; $display("FAIL spurious_res1: cycle %0d y=%h expected no pulse", cyc, res1_y);
            end else begin
                e = sb.pop_front();
                if (e.id !== 1'b1 || e.due != cyc || res1_y !== e.y) begin
                    bad++; $display("FAIL res1: cycle %0d got id1 y=%h, expected id%0d y=%h due %0d", cyc, res1_y, e.id, e.y, e.due);
                end
                last_y1 = e.y;
            end
        end else if (res1_y !== last_y1) begin
            bad++; $display("FAIL hold_y1: cycle %0d got %h expected %h", cyc, res1_y, last_y1);
        end
    end

    // One cycle of stimulus: starts just after a rising edge, ends just after the next.
    task automatic issue_cycle(input logic v0, input logic [31:0] x0,
                               input logic v1, input logic [31:0] x1);
        logic        g0, g1;
        logic [31:0] gx;
        logic [22:0] m_exp;
        req0_valid = v0; req0_x = x0;
        req1_valid = v1; req1_x = x1;
        g0 = v0 && (!v1 || !model_ptr);
        g1 = v1 && (!v0 || model_ptr);
        gx = g1 ? x1 : x0;
        m_exp = (g0 || g1) ? gx[22:0] : 23'd0;
        @(negedge clk);
        total++;
        if ({req0_ready, req1_ready} !== {g0, g1}) begin
            bad++; $display("FAIL ready: cycle %0d got %b%b expected %b%b", cyc, req0_ready, req1_ready, g0, g1);
        end
        total++;
        if (finv_m !== m_exp) begin
            bad++; $display("FAIL finv_m: cycle %0d got %h expected %h", cyc, finv_m, m_exp);
        end
        if (g0 || g1) sb.push_back('{cyc, cyc + LATENCY, g1, exp_y(gx)});
        if (v0 && v1) model_ptr = ~model_ptr;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic apply_reset(input int ncyc);
        rstn = 1'b0;
        sb.delete();
        model_ptr = 1'b0;
        last_y0 = 32'd0;
        last_y1 = 32'd0;
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL busy_on_reset: got %b expected 0", busy);
        end
        repeat (ncyc) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 3 * LATENCY + 8) begin
            issue_cycle(1'b0, 32'd0, 1'b0, 32'd0);
            n++;
        end
        issue_cycle(1'b0, 32'd0, 1'b0, 32'd0);
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    function automatic logic [31:0] rand_x();
        case ($urandom_range(0, 7))
            0:       return {$urandom_range(0, 1) == 1, 8'h00, 23'($urandom)};
            1:       return {$urandom_range(0, 1) == 1, 8'hFF, 23'($urandom)};
            2:       return {$urandom_range(0, 1) == 1, 8'($urandom_range(250, 254)), 23'($urandom)};
            default: return {$urandom_range(0, 1) == 1, 8'($urandom_range(1, 254)), 23'($urandom)};
        endcase
    endfunction

    task automatic test_reset();
        req0_valid = 1'b1; req0_x = 32'h4000_0000;
        req1_valid = 1'b1; req1_x = 32'h4040_0000;
        @(posedge clk); #1;
        total++;
        if ({req0_ready, req1_ready, res0_valid, res1_valid, busy} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl: got rdy=%b%b res=%b%b busy=%b expected all 0",
                            req0_ready, req1_ready, res0_valid, res1_valid, busy);
        end
        total++;
        if (res0_y !== 32'd0 || res1_y !== 32'd0 || finv_m !== 23'd0) begin
            bad++; $display("FAIL reset_data: got y0=%h y1=%h m=%h expected 0", res0_y, res1_y, finv_m);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rstn = 1'b1;
    endtask

    task automatic test_basic();
        issue_cycle(1'b1, 32'h4000_0000, 1'b0, 32'd0);
        drain();
    endtask

    task automatic test_special();
        issue_cycle(1'b0, 32'd0, 1'b1, 32'h0000_0000);
        issue_cycle(1'b0, 32'd0, 1'b1, 32'h8000_0000);
        issue_cycle(1'b0, 32'd0, 1'b1, 32'h7F80_0000);
        issue_cycle(1'b0, 32'd0, 1'b1, 32'hFFC0_0001);
        issue_cycle(1'b0, 32'd0, 1'b1, 32'h0012_3456);
        drain();
    endtask

    task automatic test_underflow();
        issue_cycle(1'b1, 32'h7F00_0000, 1'b0, 32'd0);
        issue_cycle(1'b1, 32'h7E80_1234, 1'b0, 32'd0);
        issue_cycle(1'b1, 32'h0080_0000, 1'b0, 32'd0);
        issue_cycle(1'b1, 32'hBF80_0000, 1'b0, 32'd0);
        drain();
    endtask

    task automatic test_arbitration();
        apply_reset(1);
        for (int i = 0; i < 4; i++)
            issue_cycle(1'b1, 32'h3F80_0000 + 32'(i << 20), 1'b1, 32'h4100_0000 + 32'(i << 19));
        drain();
    endtask

    task automatic test_reset_mid();
        issue_cycle(1'b1, 32'h4000_0000, 1'b0, 32'd0);
        issue_cycle(1'b0, 32'd0, 1'b0, 32'd0);
        apply_reset(1);
        issue_cycle(1'b0, 32'd0, 1'b1, 32'h4080_0000);
        drain();
    endtask

    task automatic test_single_stream();
        for (int i = 0; i < 10; i++)
            issue_cycle(1'b1, {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)}, 1'b0, 32'd0);
        issue_cycle(1'b1, 32'h4000_0000, 1'b1, 32'h4080_0000);
        drain();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++)
            issue_cycle(1'($urandom_range(0, 1)), rand_x(), 1'($urandom_range(0, 1)), rand_x());
        drain();
    endtask

    initial begin
        total = 0; bad = 0;
        model_ptr = 1'b0;
        last_y0 = 32'd0; last_y1 = 32'd0;
        rstn = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_x = 32'd0; req1_x = 32'd0;
        test_reset();
        test_basic();
        test_special();
        test_underflow();
        test_arbitration();
        test_reset_mid();
        test_single_stream();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish by 200000, expected completion");
        $fatal(1);
    end

endmodule
